// File: rtl/hazard_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package pipe_pkg;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b01;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_t;

  // Forwarding select for one E-stage source; the younger M result wins over W.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] rd_m,
    input logic [4:0] rd_w,
    input logic       rw_m,
    input logic       rw_w
  );
    if (rw_m && (rd_m != 5'd0) && (rd_m == src)) begin
      return FWD_M;
    end else if (rw_w && (rd_w != 5'd0) && (rd_w == src)) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard information from the pipeline and the stall/flush/forward controls back to it.
interface hazard_ctrl_if #(
  parameter int WIDTH = 32
);
  logic [4:0]       Rs1_D, Rs2_D;
  logic [4:0]       Rs1_E, Rs2_E;
  logic [4:0]       Rd_E, Rd_M, Rd_W;
  logic             regWrite_M, regWrite_W;
  logic [1:0]       resultSrc_E;
  logic             PCSrc_E;
  logic             dmem_req_M;
  logic             dmem_ready;

  logic             stall_F, stall_D, stall_E, stall_M;
  logic             flush_D, flush_E, flush_W;
  logic [1:0]       forwardA_E, forwardB_E;
  logic             mem_timeout;
  logic [WIDTH-1:0] stall_cycles;
  logic [WIDTH-1:0] redirect_count;

  // Pipeline side: reports hazards, obeys controls.
  modport master (
    output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W,
           regWrite_M, regWrite_W, resultSrc_E, PCSrc_E, dmem_req_M, dmem_ready,
    input  stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
           forwardA_E, forwardB_E, mem_timeout, stall_cycles, redirect_count
  );

  // Controller side.
  modport slave (
    input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W,
           regWrite_M, regWrite_W, resultSrc_E, PCSrc_E, dmem_req_M, dmem_ready,
    output stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
           forwardA_E, forwardB_E, mem_timeout, stall_cycles, redirect_count
  );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count one per qualifying edge, holding once full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush priority, E-stage forwarding,
// data-memory wait sequencing with a sticky timeout, and perf counters.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   RUN      | no outstanding multi-cycle memory access
//   MEM_WAIT | memory access in M still pending; whole pipe frozen
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  ctrl_state_t      state, state_nxt;
  logic [CW-1:0]    wait_cnt;
  logic             timeout_q;
  logic             load_use, mem_hold;
  logic             stall_f, stall_d, stall_e, stall_m;
  logic             flush_d, flush_e, flush_w;
  logic [WIDTH-1:0] stall_cnt, redirect_cnt;

  assign load_use = (hz.resultSrc_E == RESULT_LOAD) && (hz.Rd_E != 5'd0) &&
                    ((hz.Rd_E == hz.Rs1_D) || (hz.Rd_E == hz.Rs2_D));
  assign mem_hold = ((state == MEM_WAIT) || hz.dmem_req_M) && !hz.dmem_ready;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and prioritised stall/flush controls; a frozen E defers redirects and load-use.
  always_comb begin
    state_nxt = state;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_w   = 1'b0;

    case (state)
      RUN:      if (hz.dmem_req_M && !hz.dmem_ready) state_nxt = MEM_WAIT;
      MEM_WAIT: if (hz.dmem_ready) state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase

    if (mem_hold) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (hz.PCSrc_E) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // Wait-cycle counter: restarts on entry to MEM_WAIT, saturates at the last allowed cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if ((state == RUN) && (state_nxt == MEM_WAIT)) begin
      wait_cnt <= '0;
    end else if ((state == MEM_WAIT) && (wait_cnt != WAIT_LAST)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Sticky watchdog flag; the access itself is never aborted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else if ((state == MEM_WAIT) && !hz.dmem_ready && (wait_cnt == WAIT_LAST)) begin
      timeout_q <= 1'b1;
    end
  end

  sat_counter #(.WIDTH(WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_d),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(WIDTH)) u_redirect_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hz.PCSrc_E && !mem_hold),
    .count (redirect_cnt)
  );

  assign hz.stall_F        = stall_f;
  assign hz.stall_D        = stall_d;
  assign hz.stall_E        = stall_e;
  assign hz.stall_M        = stall_m;
  assign hz.flush_D        = flush_d;
  assign hz.flush_E        = flush_e;
  assign hz.flush_W        = flush_w;
  assign hz.mem_timeout    = timeout_q;
  assign hz.stall_cycles   = stall_cnt;
  assign hz.redirect_count = redirect_cnt;
  assign hz.forwardA_E     = fwd_sel(hz.Rs1_E, hz.Rd_M, hz.Rd_W, hz.regWrite_M, hz.regWrite_W);
  assign hz.forwardB_E     = fwd_sel(hz.Rs2_E, hz.Rd_M, hz.Rd_W, hz.regWrite_M, hz.regWrite_W);

endmodule
